zap_wb_arbiter_n: RTL

- N-master Wishbone B3 arbiter; parametrised successor of the two-port code/data merger.
- Sits between the cache/MMU masters (I-cache, D-cache, future table-walker/DMA) and the store-buffer Wishbone adapter.
- Accepts each master's next-cycle (`_nxt`) bus signals and presents one registered bus downstream.
- Burst-aware; selectable fixed-priority or round-robin arbitration; sticky flag for acks arriving with no owner.

---
 rtl/zap_wb_arbiter_n.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/zap_wb_arbiter_n.sv
// zap_wb_arbiter_n
// ----------------
// N-master Wishbone B3 arbiter. It merges the next-cycle (_nxt) bus signals
// of the cache/MMU masters into one registered bus for the store-buffer
// Wishbone adapter. Arbitration is either fixed priority (lowest index wins)
// or round-robin. Once a master owns the bus it keeps it until it drops cyc,
// so bursts are never split. One dead cycle separates consecutive owners.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_m_wb_cyc/stb/wen        per-master next-cycle controls (one bit each)
//   i_m_wb_sel/dat/adr/cti    per-master next-cycle fields, packed, master k
//                             at [k*W +: W]
//   o_m_wb_ack                downstream ack routed to the owner only
//   o_wb_cyc/stb/wen/sel/
//   o_wb_dat/adr/cti          registered downstream bus
//   i_wb_ack                  downstream ack
//   o_grant                   registered one-hot owner, zero when idle
//   o_spurious_ack            sticky: ack seen while nobody was granted
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner, bus outputs zero, arbitrating among requesters
// OWN   | rr_ptr_q is the owner; its inputs are registered onto the bus

module zap_wb_arbiter_n #(
    parameter int NUM_MASTERS = 3,
    parameter bit RR_MODE     = 1'b1,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_stb,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_wen,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  i_m_wb_sel,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_wb_dat,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_wb_adr,
    input  logic [NUM_MASTERS*3-1:0]          i_m_wb_cti,
    output logic [NUM_MASTERS-1:0]            o_m_wb_ack,
    output logic                              o_wb_cyc,
    output logic                              o_wb_stb,
    output logic                              o_wb_wen,
    output logic [SEL_WIDTH-1:0]              o_wb_sel,
    output logic [DATA_WIDTH-1:0]             o_wb_dat,
    output logic [ADDR_WIDTH-1:0]             o_wb_adr,
    output logic [2:0]                        o_wb_cti,
    input  logic                              i_wb_ack,
    output logic [NUM_MASTERS-1:0]            o_grant,
    output logic                              o_spurious_ack
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Last winner. While in OWN it is also the owner index, so no separate
    // owner register is needed.
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0] winner;
    logic             win_found;

    logic [IDX_W-1:0]      src;
    logic                  load;
    logic                  cyc_d, stb_d, wen_d;
    logic [SEL_WIDTH-1:0]  sel_d;
    logic [DATA_WIDTH-1:0] dat_d;
    logic [ADDR_WIDTH-1:0] adr_d;
    logic [2:0]            cti_d;
    logic [NUM_MASTERS-1:0] grant_d;

    // Winner search. Round-robin starts one past the last winner and wraps.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        winner    = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (RR_MODE) begin
                cand = int'(rr_ptr_q) + 1 + i;
                if (cand >= NUM_MASTERS) begin
                    cand = cand - NUM_MASTERS;
                end
            end else begin
                cand = i;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!win_found && i_m_wb_cyc[cand_idx]) begin
                win_found = 1'b1;
                winner    = cand_idx;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = OWN;
                    rr_ptr_d = winner;
                end
            end
            OWN: begin
                if (!i_m_wb_cyc[rr_ptr_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered bus. In IDLE the winner's
    // inputs are captured; in OWN the owner's inputs follow every cycle until
    // it drops cyc, at which point everything clears for the dead cycle.
    always_comb begin
        src     = (state_q == IDLE) ? winner : rr_ptr_q;
        load    = (state_q == IDLE) ? win_found : i_m_wb_cyc[rr_ptr_q];
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        wen_d   = 1'b0;
        sel_d   = '0;
        dat_d   = '0;
        adr_d   = '0;
        cti_d   = '0;
        grant_d = '0;
        if (load) begin
            cyc_d        = i_m_wb_cyc[src];
            stb_d        = i_m_wb_stb[src];
            wen_d        = i_m_wb_wen[src];
            sel_d        = i_m_wb_sel[src*SEL_WIDTH +: SEL_WIDTH];
            dat_d        = i_m_wb_dat[src*DATA_WIDTH +: DATA_WIDTH];
            adr_d        = i_m_wb_adr[src*ADDR_WIDTH +: ADDR_WIDTH];
            cti_d        = i_m_wb_cti[src*3 +: 3];
            grant_d[src] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc       <= 1'b0;
            o_wb_stb       <= 1'b0;
            o_wb_wen       <= 1'b0;
            o_wb_sel       <= '0;
            o_wb_dat       <= '0;
            o_wb_adr       <= '0;
            o_wb_cti       <= '0;
            o_grant        <= '0;
            o_spurious_ack <= 1'b0;
        end else begin
            o_wb_cyc <= cyc_d;
            o_wb_stb <= stb_d;
            o_wb_wen <= wen_d;
            o_wb_sel <= sel_d;
            o_wb_dat <= dat_d;
            o_wb_adr <= adr_d;
            o_wb_cti <= cti_d;
            o_grant  <= grant_d;
            if (i_wb_ack && (o_grant == '0)) begin
                o_spurious_ack <= 1'b1;
            end
        end
    end

    // Acks seen while reset is held are dropped rather than handed to a
    // master whose grant is about to be torn down.
    assign o_m_wb_ack = i_reset ? '0 : ({NUM_MASTERS{i_wb_ack}} & o_grant);

endmodule
